// File: rtl/stdp_depress_update.sv
// Depression-side STDP weight updater: turns a presynaptic spike into a
// lookup_minus index, then subtracts the registered table result from the weight.
module stdp_depress_update #(
   parameter int NSYN      = 16,
   parameter int IDX_W     = 4,
   parameter int W_W       = 16,
   parameter int TS_W      = 16,
   parameter int W_INIT    = 512,
   parameter int DT_MIN    = 2,
   parameter int DT_MAX    = 20,
   parameter int LUT_SHIFT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             post_spike,
   input  logic             pre_valid,
   input  logic [IDX_W-1:0] pre_idx,
   output logic             pre_ready,
   output logic [7:0]       lut_in,
   input  logic [23:0]      lut_out,
   output logic             upd_valid,
   output logic [IDX_W-1:0] upd_idx,
   output logic [W_W-1:0]   upd_weight,
   output logic             upd_skip,
   input  logic [IDX_W-1:0] wq_addr,
   output logic [W_W-1:0]   wq_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_APPLY  = 2'd2;

   logic [1:0]       state;
   logic [TS_W-1:0]  t_now;
   logic [TS_W-1:0]  t_last_post;
   logic             post_seen;
   logic [IDX_W-1:0] idx_q;
   logic [W_W-1:0]   weight [NSYN];

   logic [TS_W-1:0]  dt;
   logic             in_range;
   logic [23:0]      delta;
   logic [23:0]      w_ext;
   logic [23:0]      w_new;

   // dt uses pre-edge registers so a coincident tick/post_spike never affects it
   always_comb begin
      dt       = t_now - t_last_post;
      in_range = post_seen && (dt >= TS_W'(DT_MIN)) && (dt <= TS_W'(DT_MAX));
      delta    = lut_out >> LUT_SHIFT;
      w_ext    = 24'(weight[idx_q]);
      w_new    = (w_ext >= delta) ? (w_ext - delta) : 24'd0;
   end

   assign pre_ready = (state == S_IDLE);
   assign wq_data   = weight[wq_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         t_now       <= '0;
         t_last_post <= '0;
         post_seen   <= 1'b0;
         idx_q       <= '0;
         lut_in      <= 8'd0;
         upd_valid   <= 1'b0;
         upd_skip    <= 1'b0;
         upd_idx     <= '0;
         upd_weight  <= '0;
         for (int i = 0; i < NSYN; i++) begin
            weight[i] <= W_W'(W_INIT);
         end
      end else begin
         upd_valid <= 1'b0;
         if (tick) begin
            t_now <= t_now + 1'b1;
         end
         if (post_spike) begin
            t_last_post <= t_now;
            post_seen   <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (pre_valid) begin
                  if (in_range) begin
                     idx_q  <= pre_idx;
                     lut_in <= dt[7:0];
                     state  <= S_LOOKUP;
                  end else begin
                     upd_valid  <= 1'b1;
                     upd_skip   <= 1'b1;
                     upd_idx    <= pre_idx;
                     upd_weight <= weight[pre_idx];
                  end
               end
            end
            // the table registers lut_in at this edge; clear the index afterwards
            S_LOOKUP: begin
               lut_in <= 8'd0;
               state  <= S_APPLY;
            end
            S_APPLY: begin
               weight[idx_q] <= w_new[W_W-1:0];
               upd_valid     <= 1'b1;
               upd_skip      <= 1'b0;
               upd_idx       <= idx_q;
               upd_weight    <= w_new[W_W-1:0];
               lut_in        <= 8'd0;
               state         <= S_IDLE;
            end
            default: begin
               lut_in <= 8'd0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stdp_depress_update.sv
// Self-checking bench for stdp_depress_update with a registered lookup_minus model
// and a scoreboard of expected update pulses.
module tb_stdp_depress_update;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        post_spike;
   logic        pre_valid;
   logic [3:0]  pre_idx;
   logic        pre_ready;
   logic [7:0]  lut_in;
   logic [23:0] lut_out;
   logic        upd_valid;
   logic [3:0]  upd_idx;
   logic [15:0] upd_weight;
   logic        upd_skip;
   logic [3:0]  wq_addr;
   logic [15:0] wq_data;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] w;
      logic        skip;
      int          lat;
   } exp_t;
   exp_t sb[$];

   logic [15:0] m_t_now;
   logic [15:0] m_t_last;
   logic        m_seen;
   logic [15:0] m_w [16];

   always #5 clk = ~clk;

   stdp_depress_update dut (
      .clk(clk), .rst(rst), .tick(tick), .post_spike(post_spike),
      .pre_valid(pre_valid), .pre_idx(pre_idx), .pre_ready(pre_ready),
      .lut_in(lut_in), .lut_out(lut_out), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_weight(upd_weight), .upd_skip(upd_skip),
      .wq_addr(wq_addr), .wq_data(wq_data)
   );

   // lookup_minus stand-in: registered output, index 0 returns 0
   function automatic logic [23:0] lut_tab(input logic [7:0] i);
      case (i)
         8'd0:    lut_tab = 24'd0;
         8'd2:    lut_tab = 24'd329;
         8'd4:    lut_tab = 24'd220;
         8'd5:    lut_tab = 24'd180;
         default: lut_tab = 24'd400 - 24'(i) * 24'd10;
      endcase
   endfunction

   always_ff @(posedge clk) lut_out <= lut_tab(lut_in);

   task automatic model_reset();
      m_t_now = 16'd0;
      m_t_last = 16'd0;
      m_seen = 1'b0;
      for (int i = 0; i < 16; i++) m_w[i] = 16'd512;
   endtask

   task automatic idle_cycle(input logic tk, input logic ps);
      tick = tk;
      post_spike = ps;
      if (ps) begin
         m_t_last = m_t_now;
         m_seen = 1'b1;
      end
      if (tk) m_t_now = m_t_now + 16'd1;
      @(posedge clk); #1;
      tick = 1'b0;
      post_spike = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) idle_cycle(1'b1, 1'b0);
   endtask

   // Drive one request (optionally with coincident tick/post), push the expected
   // result, then wait a bounded number of cycles for the completion pulse.
   task automatic do_request(input logic [3:0] idx, input logic tk, input logic ps);
      exp_t e;
      exp_t got;
      logic [15:0] dt;
      logic [23:0] d;
      int cyc;
      wq_addr = idx;
      tests_run++;
      if (pre_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ready_before_req: got %b expected 1", pre_ready);
      end
      dt = m_t_now - m_t_last;
      e.idx = idx;
      if (m_seen && dt >= 16'd2 && dt <= 16'd20) begin
         d = lut_tab(dt[7:0]);
         m_w[idx] = (24'(m_w[idx]) >= d) ? m_w[idx] - d[15:0] : 16'd0;
         e.w = m_w[idx];
         e.skip = 1'b0;
         e.lat = 3;
      end else begin
         e.w = m_w[idx];
         e.skip = 1'b1;
         e.lat = 1;
      end
      sb.push_back(e);
      pre_valid = 1'b1;
      pre_idx = idx;
      tick = tk;
      post_spike = ps;
      if (ps) begin
         m_t_last = m_t_now;
         m_seen = 1'b1;
      end
      if (tk) m_t_now = m_t_now + 16'd1;
      @(posedge clk); #1;
      pre_valid = 1'b0;
      tick = 1'b0;
      post_spike = 1'b0;
      cyc = 1;
      tests_run++;
      if (lut_in !== (e.skip ? 8'd0 : dt[7:0])) begin
         tests_failed++;
         $display("[TB] FAIL lut_in_after_accept: got %0d expected %0d", lut_in, e.skip ? 8'd0 : dt[7:0]);
      end
      while (upd_valid !== 1'b1 && cyc < 8) begin
         tests_run++;
         if (pre_ready !== e.skip) begin
            tests_failed++;
            $display("[TB] FAIL ready_busy: cycle %0d got %b expected %b", cyc, pre_ready, e.skip);
         end
         @(posedge clk); #1;
         cyc++;
      end
      tests_run++;
      if (upd_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL upd_timeout: got no upd_valid expected one within 8 cycles");
         void'(sb.pop_front());
      end else begin
         got = sb.pop_front();
         if (cyc !== got.lat || upd_idx !== got.idx || upd_weight !== got.w ||
             upd_skip !== got.skip || wq_data !== got.w || pre_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL upd_result: got lat=%0d idx=%0d w=%0d skip=%b wq=%0d rdy=%b expected lat=%0d idx=%0d w=%0d skip=%b",
                     cyc, upd_idx, upd_weight, upd_skip, wq_data, pre_ready, got.lat, got.idx, got.w, got.skip);
         end
      end
      @(posedge clk); #1;
      tests_run++;
      if (upd_valid !== 1'b0 || lut_in !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL upd_pulse_width: got valid=%b lut_in=%0d expected 0 0", upd_valid, lut_in);
      end
   endtask

   task automatic check_weight(input logic [3:0] idx, input logic [15:0] exp_w);
      wq_addr = idx;
      #1;
      tests_run++;
      if (wq_data !== exp_w) begin
         tests_failed++;
         $display("[TB] FAIL weight[%0d]: got %0d expected %0d", idx, wq_data, exp_w);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tests_run++;
      if (upd_valid !== 1'b0 || upd_skip !== 1'b0 || upd_idx !== 4'd0 ||
          upd_weight !== 16'd0 || lut_in !== 8'd0 || pre_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got v=%b s=%b i=%0d w=%0d lut=%0d rdy=%b expected 0 0 0 0 0 1",
                  upd_valid, upd_skip, upd_idx, upd_weight, lut_in, pre_ready);
      end
      for (int i = 0; i < 16; i++) check_weight(4'(i), 16'd512);
   endtask

   task automatic test_no_post();
      do_request(4'd3, 1'b0, 1'b0);
      check_weight(4'd3, 16'd512);
   endtask

   task automatic test_basic_depress();
      idle_cycle(1'b0, 1'b1);
      ticks(5);
      do_request(4'd3, 1'b0, 1'b0);
      check_weight(4'd3, 16'd332);
   endtask

   task automatic test_saturation();
      ticks(10 - int'(m_t_now));
      idle_cycle(1'b0, 1'b1);
      ticks(2);
      do_request(4'd7, 1'b0, 1'b0);
      check_weight(4'd7, 16'd183);
      do_request(4'd7, 1'b0, 1'b0);
      check_weight(4'd7, 16'd0);
   endtask

   task automatic test_out_of_range();
      idle_cycle(1'b0, 1'b1);
      ticks(1);
      do_request(4'd4, 1'b0, 1'b0);
      ticks(20);
      do_request(4'd4, 1'b0, 1'b0);
      check_weight(4'd4, 16'd512);
      check_weight(4'd3, 16'd332);
   endtask

   task automatic test_coincident();
      ticks(100 - int'(m_t_now));
      idle_cycle(1'b0, 1'b1);
      ticks(4);
      do_request(4'd9, 1'b1, 1'b1);
      check_weight(4'd9, 16'd292);
      ticks(1);
      do_request(4'd10, 1'b0, 1'b0);
      check_weight(4'd10, 16'd183);
   endtask

   task automatic test_reset_in_apply();
      ticks(1);
      idle_cycle(1'b0, 1'b1);
      ticks(2);
      pre_valid = 1'b1;
      pre_idx = 4'd5;
      @(posedge clk); #1;
      pre_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++;
      if (upd_valid !== 1'b0 || pre_ready !== 1'b1 || lut_in !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_apply: got v=%b rdy=%b lut=%0d expected 0 1 0", upd_valid, pre_ready, lut_in);
      end
      @(posedge clk); #1;
      tests_run++;
      if (upd_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL stale_lut_ignored: got %b expected 0", upd_valid);
      end
      check_weight(4'd5, 16'd512);
      check_weight(4'd3, 16'd512);
      do_request(4'd5, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      post_spike = 1'b0;
      pre_valid = 1'b0;
      pre_idx = 4'd0;
      wq_addr = 4'd0;
      test_reset();
      test_no_post();
      test_basic_depress();
      test_saturation();
      test_out_of_range();
      test_coincident();
      test_reset_in_apply();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
